// File: rtl/cordic_pkg.sv
// Shared constants, mode encodings and FSM states for the iterative CORDIC engine.
// Angles and gains are Q1.30; consumers shift them down to their own fraction width.
package cordic_pkg;

  localparam int CNT_W = 5;

  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_VECTOR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic signed [63:0] K_Q30   = 64'sd652032874;
  localparam logic signed [63:0] PI_Q30  = 64'sd3373259426;
  localparam logic signed [63:0] PIH_Q30 = 64'sd1686629713;

  // atan(2^-i) scaled by 2^30
  localparam logic [31:0] ATAN_Q30 [32] = '{
    32'd843314857, 32'd497837829, 32'd263043836, 32'd133525159,
    32'd67021686,  32'd33543516,  32'd16775851,  32'd8388437,
    32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
    32'd262144,    32'd131072,    32'd65536,     32'd32768,
    32'd16384,     32'd8192,      32'd4096,      32'd2048,
    32'd1024,      32'd512,       32'd256,       32'd128,
    32'd64,        32'd32,        32'd16,        32'd8,
    32'd4,         32'd2,         32'd1,         32'd0
  };

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC shift-add micro-rotation, reused every iteration.
// Zero latency; no handshake, the owning FSM decides when results are taken.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int IW = 34
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [IW-1:0] z,
  input  logic [CNT_W-1:0]     i,
  input  logic [1:0]           mode,
  input  logic signed [IW-1:0] atan_i,
  output logic signed [IW-1:0] x_nxt,
  output logic signed [IW-1:0] y_nxt,
  output logic signed [IW-1:0] z_nxt
);

  logic                 d_pos;
  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  always_comb begin
    // rotate drives z to zero; vector drives y to zero
    d_pos = (mode == MODE_ROTATE) ? ~z[IW-1] : y[IW-1];
    x_sh  = x >>> i;
    y_sh  = y >>> i;
    if (d_pos) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_i;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_i;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC (rotate: cos/sin, vector: magnitude/atan2), one micro-rotation per clock.
// Result valid ITER+1 cycles after accept; result held until out_ready, in_ready low while busy.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int DW   = 32,
  parameter int FRAC = 28,
  parameter int ITER = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic signed [DW-1:0] din_x,
  input  logic signed [DW-1:0] din_y,
  input  logic signed [DW-1:0] din_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] res0,
  output logic signed [DW-1:0] res1,
  output logic                 out_err
);

  localparam int IW = DW + 2;
  localparam int SH = 30 - FRAC;

  localparam logic signed [IW-1:0] K_I   = IW'(K_Q30 >>> SH);
  localparam logic signed [IW-1:0] PI_I  = IW'(PI_Q30 >>> SH);
  localparam logic signed [IW-1:0] PIH_I = IW'(PIH_Q30 >>> SH);

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  logic [1:0]           req_mode;
  logic signed [DW-1:0] req_x, req_y, req_z;
  logic signed [IW-1:0] req_x_ext, req_y_ext, req_z_ext;
  logic                 req_legal;
  logic                 vec_zero;

  logic signed [IW-1:0] x, y, z;
  logic signed [IW-1:0] pre_x, pre_y, pre_z;
  logic signed [IW-1:0] rot_x, rot_y, rot_z;
  logic signed [IW-1:0] atan_i;

  assign req_x_ext = {{2{req_x[DW-1]}}, req_x};
  assign req_y_ext = {{2{req_y[DW-1]}}, req_y};
  assign req_z_ext = {{2{req_z[DW-1]}}, req_z};
  assign req_legal = (req_mode == MODE_ROTATE) || (req_mode == MODE_VECTOR);
  assign vec_zero  = (req_x == '0) && (req_y == '0);
  assign atan_i    = IW'($signed({1'b0, ATAN_Q30[cnt]}) >>> SH);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_PRE;
        end
      end
      ST_PRE: state_nxt = ST_ITER;
      ST_ITER: begin
        if (cnt == CNT_W'(ITER - 1)) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = ST_PRE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // quadrant correction keeps the iteration inside its +/-pi/2 convergence range
  always_comb begin
    pre_x = '0;
    pre_y = '0;
    pre_z = '0;
    if (req_mode == MODE_ROTATE) begin
      pre_x = K_I;
      pre_z = req_z_ext;
      if (req_z_ext > PIH_I) begin
        pre_z = req_z_ext - PI_I;
        pre_x = -K_I;
      end else if (req_z_ext < -PIH_I) begin
        pre_z = req_z_ext + PI_I;
        pre_x = -K_I;
      end
    end else if (req_mode == MODE_VECTOR) begin
      pre_x = req_x_ext;
      pre_y = req_y_ext;
      if (req_x[DW-1]) begin
        pre_x = -req_x_ext;
        pre_y = -req_y_ext;
        pre_z = req_y[DW-1] ? -PI_I : PI_I;
      end
    end
  end

  cordic_micro_rot #(
    .IW(IW)
  ) u_rot (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (cnt),
    .mode   (req_mode),
    .atan_i (atan_i),
    .x_nxt  (rot_x),
    .y_nxt  (rot_y),
    .z_nxt  (rot_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_mode <= MODE_ROTATE;
      req_x    <= '0;
      req_y    <= '0;
      req_z    <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      res0     <= '0;
      res1     <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_mode <= mode;
        req_x    <= din_x;
        req_y    <= din_y;
        req_z    <= din_z;
        if ((mode == MODE_ROTATE) || (mode == MODE_VECTOR)) begin
          out_err <= 1'b0;
        end
      end
      if (state == ST_PRE) begin
        x   <= pre_x;
        y   <= pre_y;
        z   <= pre_z;
        cnt <= '0;
      end
      if (state == ST_ITER) begin
        cnt <= cnt + 1'b1;
        if (req_legal) begin
          x <= rot_x;
          y <= rot_y;
          z <= rot_z;
        end
        if (last) begin
          if (!req_legal) begin
            res0    <= '0;
            res1    <= '0;
            out_err <= 1'b1;
          end else if ((req_mode == MODE_VECTOR) && vec_zero) begin
            // a zero vector has no defined angle; report it as all zeros
            res0    <= '0;
            res1    <= '0;
            out_err <= 1'b0;
          end else begin
            res0    <= rot_x[DW-1:0];
            res1    <= (req_mode == MODE_VECTOR) ? rot_z[DW-1:0] : rot_y[DW-1:0];
            out_err <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine at DW=32, FRAC=28, ITER=16 (1.0 = 2^28).
module tb_cordic_iter_engine;

  localparam int     DW  = 32;
  localparam longint TOL = 16384;
  localparam int     ONE = 268435456;
  localparam int     PI6 = 140552476;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           mode = 2'b00;
  logic signed [DW-1:0] din_x = '0;
  logic signed [DW-1:0] din_y = '0;
  logic signed [DW-1:0] din_z = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] res0;
  logic signed [DW-1:0] res1;
  logic                 out_err;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_iter_engine #(.DW(DW), .FRAC(28), .ITER(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .din_x     (din_x),
    .din_y     (din_y),
    .din_z     (din_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res0      (res0),
    .res1      (res1),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    n_cmp++;
    if ((got > exp + tol) || (got < exp - tol)) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic send(input logic [1:0] m, input int x, input int y, input int z);
    int n;
    @(negedge clk);
    mode = m; din_x = x; din_y = y; din_z = z; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", longint'(n < 50), 1, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input int x, input int y, input int z,
                        input longint e0, input longint e1, input longint tol, input logic e_err);
    int lat;
    send(m, x, y, z);
    wait_out(lat);
    check({tag, "_lat"}, lat, 17, 0);
    check({tag, "_res0"}, res0, e0, tol);
    check({tag, "_res1"}, res1, e1, tol);
    check({tag, "_err"}, out_err, e_err, 0);
    pop();
  endtask

  int     zs  [3] = '{PI6, -805306368, 0};
  longint e0s [3] = '{232471924, -265749087, 268435456};
  longint e1s [3] = '{134217728, -37881614, 0};

  initial begin
    int     lat, got, sent;
    int     t_out [3];
    longint r0 [3];
    longint r1 [3];
    logic   acc;

    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1, 0);
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_res0", res0, 0, 0);
    check("rst_res1", res1, 0, 0);
    check("rst_err", out_err, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("rot_pi6", 2'b00, 0, 0, PI6, 232471924, 134217728, TOL, 1'b0);
    run_op("rot_5pi6", 2'b00, 0, 0, 702762380, -232471924, 134217728, TOL, 1'b0);
    run_op("rot_m3", 2'b00, 0, 0, -805306368, -265749087, -37881614, TOL, 1'b0);
    run_op("vec_negx", 2'b01, -ONE, 0, 0, 442048861, 843314857, TOL, 1'b0);
    run_op("vec_negy", 2'b01, 0, -ONE, 0, 442048861, -421657428, TOL, 1'b0);
    run_op("vec_zero", 2'b01, 0, 0, 0, 0, 0, 0, 1'b0);

    // back-to-back with the consumer always ready
    got = 0; sent = 0;
    @(negedge clk);
    mode = 2'b00; din_x = 0; din_y = 0; din_z = zs[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 3; c++) begin
      if (out_valid) begin
        t_out[got] = c; r0[got] = res0; r1[got] = res1;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent < 3) din_z = zs[sent];
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_count", got, 3, 0);
    if (got == 3) begin
      check("b2b_gap01", t_out[1] - t_out[0], 18, 0);
      check("b2b_gap12", t_out[2] - t_out[1], 18, 0);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("b2b_res0_%0d", k), r0[k], e0s[k], TOL);
        check($sformatf("b2b_res1_%0d", k), r1[k], e1s[k], TOL);
      end
    end

    // stall: result and in_ready must hold while out_ready is low
    send(2'b00, 0, 0, PI6);
    wait_out(lat);
    check("hold_lat", lat, 17, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1, 0);
      check("hold_in_ready", in_ready, 0, 0);
      check("hold_res0", res0, 232471924, TOL);
      check("hold_res1", res1, 134217728, TOL);
    end
    pop();

    run_op("rsv", 2'b10, ONE, ONE, PI6, 0, 0, 0, 1'b1);
    run_op("rsv_clear", 2'b00, 0, 0, PI6, 232471924, 134217728, TOL, 1'b0);

    // reset while iterating (counter at 7)
    send(2'b00, 0, 0, -PI6);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0, 0);
    check("midrst_in_ready", in_ready, 1, 0);
    check("midrst_res0", res0, 0, 0);
    check("midrst_err", out_err, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b00, 0, 0, -PI6, 232471924, -134217728, TOL, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, want finish before 500000 ns");
    $fatal(1, "time limit");
  end

endmodule
